// File: rtl/dither_channel_sched_pkg.sv
// -----------------------------------------------------------------------------
// dither_pkg
// Shared types and helpers for the RGB dither channel scheduler.
//   sched_state_t : scheduler FSM state encoding
//   ch_idx_t      : channel index (0=R, 1=G, 2=B)
//   rgb24_t       : packed pixel {B[23:16], G[15:8], R[7:0]}
//   get_byte/set_byte : per-channel byte access on an rgb24_t
// -----------------------------------------------------------------------------
package dither_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } sched_state_t;

  typedef logic [1:0]  ch_idx_t;
  typedef logic [23:0] rgb24_t;

  localparam ch_idx_t CH_R    = 2'd0;
  localparam ch_idx_t CH_G    = 2'd1;
  localparam ch_idx_t CH_B    = 2'd2;
  localparam ch_idx_t CH_LAST = 2'd2;

  // Index 3 never occurs; it falls back to R so the mux stays total.
  function automatic logic [7:0] get_byte(rgb24_t p, ch_idx_t c);
    case (c)
      CH_G:    return p[15:8];
      CH_B:    return p[23:16];
      default: return p[7:0];
    endcase
  endfunction

  function automatic rgb24_t set_byte(rgb24_t p, ch_idx_t c, logic [7:0] b);
    rgb24_t r;
    r = p;
    case (c)
      CH_G:    r[15:8]  = b;
      CH_B:    r[23:16] = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dither_channel_sched_if.sv
// -----------------------------------------------------------------------------
// dither_channel_sched_if
// Pixel stream and engine handshake bundle for dither_channel_sched.
//   in_valid/in_data/in_ready    : pixel source -> scheduler
//   out_valid/out_data/out_ready : scheduler -> VGA output stage
//   eng_req/eng_data/eng_ch      : scheduler -> dithering engine request
//   eng_rvalid/eng_rdata         : dithering engine -> scheduler result
// Modports: slave = scheduler side, master = environment side.
// -----------------------------------------------------------------------------
interface dither_channel_sched_if;
  import dither_pkg::*;

  logic       in_valid;
  rgb24_t     in_data;
  logic       in_ready;
  logic       out_valid;
  rgb24_t     out_data;
  logic       out_ready;
  logic       eng_req;
  logic [7:0] eng_data;
  ch_idx_t    eng_ch;
  logic       eng_rvalid;
  logic [7:0] eng_rdata;

  modport slave (
    input  in_valid, in_data, out_ready, eng_rvalid, eng_rdata,
    output in_ready, out_valid, out_data, eng_req, eng_data, eng_ch
  );

  modport master (
    output in_valid, in_data, out_ready, eng_rvalid, eng_rdata,
    input  in_ready, out_valid, out_data, eng_req, eng_data, eng_ch
  );

endinterface

// File: rtl/dither_channel_sched_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic 1-bit two-flop synchronizer, asynchronous active-high reset to 0.
//   clk : destination clock
//   rst : asynchronous active-high reset
//   d_i : asynchronous input
//   q_o : synchronized output (2 cycles of latency)
// Only compiled when DITHER_SCHED_SYNC_EN is defined, which is also the only
// build in which the scheduler instantiates it.
// -----------------------------------------------------------------------------
`ifdef DITHER_SCHED_SYNC_EN
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`endif

// File: rtl/dither_channel_sched.sv
// -----------------------------------------------------------------------------
// dither_channel_sched
// Shares one 8-bit dithering engine among the R, G and B bytes of a 24-bit
// pixel stream. A pixel is accepted in IDLE, its three bytes are issued to the
// engine one at a time, results are collected, and the reassembled pixel is
// presented on the output. With SW=0 the pixel bypasses the engine.
//
// Parameters:
//   TIMEOUT : max WAIT cycles per engine response (1..255)
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   SW       : mode, 1 = dither, 0 = bypass; sampled only at pixel accept
//   bus      : dither_channel_sched_if.slave (pixel in/out, engine req/resp)
//   err      : sticky engine-timeout flag, cleared only by rst
// Build option:
//   DITHER_SCHED_SYNC_EN : route SW through a 2-flop synchronizer first.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | in_ready=1, waiting for a pixel
// ISSUE  | eng_req pulse for channel ch, timeout counter reloaded
// WAIT   | waiting for eng_rvalid or timeout on channel ch
// OUT    | out_valid=1 holding the result until out_ready
// -----------------------------------------------------------------------------
module dither_channel_sched
  import dither_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SW,
  dither_channel_sched_if.slave  bus,
  output logic                   err
);

  // Down-counter load: terminal count 0 is reached on the TIMEOUT-th WAIT cycle.
  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);

  logic sw_eff;

`ifdef DITHER_SCHED_SYNC_EN
  sync_2ff u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d_i (SW),
    .q_o (sw_eff)
  );
`else
  assign sw_eff = SW;
`endif

  sched_state_t state_q, state_d;
  ch_idx_t      ch_q, ch_d;
  logic [7:0]   cnt_q, cnt_d;
  rgb24_t       pix_q, pix_d;
  rgb24_t       res_q, res_d;
  logic         out_valid_q, out_valid_d;
  rgb24_t       out_data_q, out_data_d;
  logic         eng_req_q, eng_req_d;
  logic [7:0]   eng_data_q, eng_data_d;
  ch_idx_t      eng_ch_q, eng_ch_d;
  logic         err_q, err_d;

  ch_idx_t      ch_nxt;
  rgb24_t       res_upd;

  // On timeout the untouched input byte stands in for the engine result.
  assign ch_nxt  = ch_q + 2'd1;
  assign res_upd = set_byte(res_q, ch_q,
                            bus.eng_rvalid ? bus.eng_rdata : get_byte(pix_q, ch_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= CH_R;
      cnt_q       <= 8'd0;
      pix_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      eng_req_q   <= 1'b0;
      eng_data_q  <= 8'd0;
      eng_ch_q    <= CH_R;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      pix_q       <= pix_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      eng_req_q   <= eng_req_d;
      eng_data_q  <= eng_data_d;
      eng_ch_q    <= eng_ch_d;
      err_q       <= err_d;
    end
  end

  // Registered outputs are computed one cycle ahead: the eng_req pulse is
  // raised on the transition into ISSUE, out_valid on the transition into OUT.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    pix_d       = pix_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    eng_req_d   = 1'b0;
    eng_data_d  = eng_data_q;
    eng_ch_d    = eng_ch_q;
    err_d       = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          pix_d = bus.in_data;
          if (sw_eff) begin
            ch_d       = CH_R;
            eng_req_d  = 1'b1;
            eng_data_d = get_byte(bus.in_data, CH_R);
            eng_ch_d   = CH_R;
            state_d    = ST_ISSUE;
          end else begin
            res_d       = bus.in_data;
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data;
            state_d     = ST_OUT;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = TO_LOAD;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // A response arriving in the expiry cycle takes priority over timeout.
        if (bus.eng_rvalid || (cnt_q == 8'd0)) begin
          res_d = res_upd;
          if (!bus.eng_rvalid) begin
            err_d = 1'b1;
          end
          if (ch_q == CH_LAST) begin
            out_valid_d = 1'b1;
            out_data_d  = res_upd;
            state_d     = ST_OUT;
          end else begin
            ch_d       = ch_nxt;
            eng_req_d  = 1'b1;
            eng_data_d = get_byte(pix_q, ch_nxt);
            eng_ch_d   = ch_nxt;
            state_d    = ST_ISSUE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.eng_req   = eng_req_q;
  assign bus.eng_data  = eng_data_q;
  assign bus.eng_ch    = eng_ch_q;
  assign err           = err_q;

endmodule

// File: tb/tb_dither_channel_sched.sv
module tb_dither_channel_sched;
  import dither_pkg::*;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SW  = 1'b0;
  logic err;

  dither_channel_sched_if ifc ();

  dither_channel_sched #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .SW  (SW),
    .bus (ifc.slave),
    .err (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         c;
    logic [1:0] ch;
    logic [7:0] d;
  } req_t;

  logic [23:0] exp_q[$];
  req_t        req_log[$];
  int          eng_delay[3];

  // engine stub state
  bit          e_pend  = 1'b0;
  int          e_cnt   = 0;
  logic [7:0]  e_data  = 8'd0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (ifc.eng_req === 1'b1) req_log.push_back('{c: cyc, ch: ifc.eng_ch, d: ifc.eng_data});
  end

  // Engine stub: answers byte^0xFF eng_delay[ch] cycles after the request;
  // delay 0 means silent. Deliberately unaware of rst.
  initial begin
    ifc.eng_rvalid = 1'b0;
    ifc.eng_rdata  = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      ifc.eng_rvalid = 1'b0;
      if (e_pend) begin
        if (e_cnt <= 1) begin
          ifc.eng_rvalid = 1'b1;
          ifc.eng_rdata  = e_data;
          e_pend = 1'b0;
        end else begin
          e_cnt--;
        end
      end
      if (ifc.eng_req === 1'b1 && eng_delay[ifc.eng_ch] > 0) begin
        e_pend = 1'b1;
        e_cnt  = eng_delay[ifc.eng_ch];
        e_data = ifc.eng_data ^ 8'hFF;
      end
    end
  end

  function automatic logic [23:0] model(logic [23:0] p);
    logic [23:0] r;
    r = p;
    for (int i = 0; i < 3; i++) begin
      if (eng_delay[i] > 0 && eng_delay[i] <= int'(TO)) r[8*i +: 8] = p[8*i +: 8] ^ 8'hFF;
    end
    return r;
  endfunction

  task automatic accept(input logic sw, input logic [23:0] d, output bit ok);
    SW = sw;
    ifc.in_data  = d;
    ifc.in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ifc.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #2;
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (ifc.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #2;
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [23:0] got[7];
    logic [23:0] want[7];
    string       nm[7];
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    nm = '{"rst_out_valid", "rst_out_data", "rst_eng_req", "rst_eng_data", "rst_eng_ch", "rst_err", "rst_in_ready"};
    got  = '{24'(ifc.out_valid), ifc.out_data, 24'(ifc.eng_req), 24'(ifc.eng_data), 24'(ifc.eng_ch), 24'(err), 24'(ifc.in_ready)};
    want = '{24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd1};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL %s got %0h want %0h", nm[i], got[i], want[i]);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_in_ready got %b want 1", ifc.in_ready);
    end
  endtask

  task automatic test_bypass();
    bit ok;
    logic [23:0] e;
    req_log.delete();
    exp_q.push_back(24'h123456);
    accept(1'b0, 24'h123456, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL byp_accept got 0 want 1"); end
    checks++;
    if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL byp_valid_T1 got %b want 1", ifc.out_valid); end
    e = exp_q.pop_front();
    checks++;
    if (ifc.out_data !== e) begin errors++; $display("FAIL byp_data got %h want %h", ifc.out_data, e); end
    @(posedge clk);
    #2;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL byp_return got valid=%b ready=%b want valid=0 ready=1", ifc.out_valid, ifc.in_ready);
    end
    checks++;
    if (req_log.size() != 0) begin errors++; $display("FAIL byp_no_eng_req got %0d reqs want 0", req_log.size()); end
  endtask

  task automatic test_dither();
    bit ok;
    int t1, lat;
    logic [23:0] e;
    logic [7:0] eb[3];
    eb = '{8'h80, 8'hFF, 8'h00};
    eng_delay = '{1, 1, 1};
    req_log.delete();
    exp_q.push_back(24'hFF007F);
    accept(1'b1, 24'h00FF80, ok);
    t1 = cyc;
    wait_out(lat);
    checks++;
    if (!ok || lat != 7) begin errors++; $display("FAIL dith_latency got %0d want 7", lat); end
    e = exp_q.pop_front();
    checks++;
    if (ifc.out_data !== e) begin errors++; $display("FAIL dith_data got %h want %h", ifc.out_data, e); end
    checks++;
    if (req_log.size() != 3) begin
      errors++;
      $display("FAIL dith_req_count got %0d want 3", req_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (req_log[i].c != t1 + 2*i || req_log[i].ch !== 2'(i) || req_log[i].d !== eb[i]) begin
          errors++;
          $display("FAIL dith_req%0d got cyc=%0d ch=%0d data=%h want cyc=%0d ch=%0d data=%h",
                   i, req_log[i].c, req_log[i].ch, req_log[i].d, t1 + 2*i, i, eb[i]);
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_expiry();
    bit ok;
    int lat;
    logic [23:0] e;
    eng_delay = '{1, int'(TO), 1};
    exp_q.push_back(model(24'h123456));
    accept(1'b1, 24'h123456, ok);
    wait_out(lat);
    checks++;
    if (!ok || lat != 1 + 2 + (1 + int'(TO)) + 2) begin
      errors++;
      $display("FAIL exp_latency got %0d want %0d", lat, 1 + 2 + (1 + int'(TO)) + 2);
    end
    e = exp_q.pop_front();
    checks++;
    if (ifc.out_data !== e) begin errors++; $display("FAIL exp_data got %h want %h", ifc.out_data, e); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL exp_err got %b want 0", err); end
    @(posedge clk);
    #2;
  endtask

  task automatic test_timeout();
    bit ok;
    int lat;
    logic [23:0] e;
    eng_delay = '{1, 0, 1};
    exp_q.push_back(model(24'h4411AA));
    accept(1'b1, 24'h4411AA, ok);
    wait_out(lat);
    checks++;
    if (!ok || lat != 1 + 2 + (1 + int'(TO)) + 2) begin
      errors++;
      $display("FAIL to_latency got %0d want %0d", lat, 1 + 2 + (1 + int'(TO)) + 2);
    end
    e = exp_q.pop_front();
    checks++;
    if (ifc.out_data !== e) begin errors++; $display("FAIL to_data got %h want %h", ifc.out_data, e); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", err); end
    @(posedge clk);
    #2;
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [23:0] e;
    eng_delay = '{1, 1, 1};
    ifc.out_ready = 1'b0;
    exp_q.push_back(24'hA1B2C3);
    accept(1'b0, 24'hA1B2C3, ok);
    SW = 1'b1;
    ifc.in_data  = 24'h0C0D0E;
    ifc.in_valid = 1'b1;
    exp_q.push_back(model(24'h0C0D0E));
    req_log.delete();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.out_data !== exp_q[0] || ifc.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b data=%h ready=%b want valid=1 data=%h ready=0",
                 i, ifc.out_valid, ifc.out_data, ifc.in_ready, exp_q[0]);
      end
      @(posedge clk);
      #2;
    end
    checks++;
    if (req_log.size() != 0) begin errors++; $display("FAIL bp_no_accept got %0d reqs want 0", req_log.size()); end
    ifc.out_ready = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (ifc.out_data !== e) begin errors++; $display("FAIL bp_data1 got %h want %h", ifc.out_data, e); end
    @(posedge clk);
    #2;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", ifc.out_valid, ifc.in_ready);
    end
    @(posedge clk);
    #2;
    ifc.in_valid = 1'b0;
    checks++;
    if (ifc.in_ready !== 1'b0 || ifc.eng_req !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept2 got ready=%b eng_req=%b want ready=0 eng_req=1", ifc.in_ready, ifc.eng_req);
    end
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (lat != 7 || ifc.out_data !== e) begin
      errors++;
      $display("FAIL bp_data2 got lat=%0d data=%h want lat=7 data=%h", lat, ifc.out_data, e);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset_mid();
    bit ok, found, seen;
    int lat;
    logic [23:0] e;
    eng_delay = '{1, 3, 1};
    accept(1'b1, 24'h334455, ok);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (ifc.eng_req === 1'b1 && ifc.eng_ch === CH_G) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rm_reach_ch1 got none want eng_req on ch1"); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_data !== 24'd0 || ifc.eng_req !== 1'b0 ||
        ifc.eng_data !== 8'd0 || ifc.eng_ch !== 2'd0 || err !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_outputs got v=%b d=%h rq=%b ed=%h ch=%0d err=%b rdy=%b want all 0 rdy=1",
               ifc.out_valid, ifc.out_data, ifc.eng_req, ifc.eng_data, ifc.eng_ch, err, ifc.in_ready);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #2;
      if (ifc.out_valid !== 1'b0 || ifc.eng_req !== 1'b0 || ifc.in_ready !== 1'b1 || err !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rm_stale_rvalid got activity want idle"); end
    eng_delay = '{1, 1, 1};
    exp_q.push_back(model(24'h010203));
    accept(1'b1, 24'h010203, ok);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (!ok || lat != 7 || ifc.out_data !== e || err !== 1'b0) begin
      errors++;
      $display("FAIL rm_next_pixel got lat=%0d data=%h err=%b want lat=7 data=%h err=0", lat, ifc.out_data, err, e);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    eng_delay     = '{1, 1, 1};
    test_reset();
    test_bypass();
    test_dither();
    test_expiry();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
